// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the serial sequence detector:
// state width, prefix/suffix lengths and the KMP fallback used to build its tables.
package seq_det_pkg;

    localparam int N_MIN = 2;
    localparam int N_MAX = 16;

    typedef logic [$clog2(N_MAX)-1:0] state_max_t;

    function automatic int state_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Longest proper prefix of PATTERN[n-1:n-k] that is also a suffix of it.
    function automatic int prefix_suffix_len(input logic [15:0] pat, input int n, input int k);
        int  best;
        bit  ok;
        best = 0;
        for (int l = 1; l < k; l++) begin
            ok = 1'b1;
            for (int i = 0; i < l; i++) begin
                if (pat[n-1-i] != pat[n-k+l-1-i]) begin
                    ok = 1'b0;
                end else begin
                    ok = ok;
                end
            end
            if (ok) begin
                best = l;
            end else begin
                best = best;
            end
        end
        return best;
    endfunction

    function automatic int kmp_next(input logic [15:0] pat, input int n, input int k, input logic b);
        int j;
        int res;
        bit done;
        j    = k;
        res  = 0;
        done = 1'b0;
        for (int it = 0; it <= N_MAX; it++) begin
            if (!done) begin
                if (j < n && pat[n-1-j] == b) begin
                    res  = j + 1;
                    done = 1'b1;
                end else if (j == 0) begin
                    res  = 0;
                    done = 1'b1;
                end else begin
                    j = prefix_suffix_len(pat, n, j);
                end
            end else begin
                done = done;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_det_next.sv
// Combinational transition function of the detector: (state, bit) -> (next state, match),
// driven by per-state tables computed at elaboration.
module seq_det_next
    import seq_det_pkg::*;
#(
    parameter int          N       = 4,
    parameter logic [15:0] PATTERN = 16'b1011,
    parameter int          OVERLAP = 1,
    parameter int          SW      = state_w(N)
) (
    input  logic [SW-1:0] state_i,
    input  logic          x_i,
    output logic [SW-1:0] next_o,
    output logic          match_o
);

    localparam int NS = 2 ** SW;
    localparam int F  = prefix_suffix_len(PATTERN, N, N);

    logic [SW-1:0] nxt0_tab [NS];
    logic [SW-1:0] nxt1_tab [NS];

    // Encodings at or above N are unreachable and simply fall back to the empty state.
    for (genvar k = 0; k < NS; k++) begin : g_tab
        if (k < N) begin : g_live
            localparam int NX0 = (k == N-1 && PATTERN[0] == 1'b0) ? ((OVERLAP != 0) ? F : 0)
                                                                   : kmp_next(PATTERN, N, k, 1'b0);
            localparam int NX1 = (k == N-1 && PATTERN[0] == 1'b1) ? ((OVERLAP != 0) ? F : 0)
                                                                   : kmp_next(PATTERN, N, k, 1'b1);
            assign nxt0_tab[k] = SW'(NX0);
            assign nxt1_tab[k] = SW'(NX1);
        end else begin : g_dead
            assign nxt0_tab[k] = '0;
            assign nxt1_tab[k] = '0;
        end
    end

    // Table lookup and match decode.
    always_comb begin
        next_o  = x_i ? nxt1_tab[state_i] : nxt0_tab[state_i];
        match_o = (state_i == SW'(N-1)) && (x_i == PATTERN[0]);
    end

endmodule

// File: rtl/seq_det_fsm.sv
// Parametrised serial sequence detector with saturating match counter and debug state.
// Define SEQ_DET_REGOUT_EN to register y_out (one-cycle-late pulse); otherwise y_out is Mealy.
module seq_det_fsm
    import seq_det_pkg::*;
#(
    parameter int          N       = 4,
    parameter logic [15:0] PATTERN = 16'b1011,
    parameter int          OVERLAP = 1,
    parameter int          CNT_W   = 8,
    localparam int         SW      = state_w(N)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             x_in,
    input  logic             x_valid,
    input  logic             cnt_clr,
    output logic             y_out,
    output logic [CNT_W-1:0] match_cnt,
    output logic [SW-1:0]    state_out
);

    if (N < N_MIN || N > N_MAX) begin : g_bad_n
        $error("seq_det_fsm: N out of legal range");
    end
    if ((PATTERN >> N) != 16'd0) begin : g_bad_pattern
        $error("seq_det_fsm: PATTERN has bits set above N-1");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SW-1:0]    state_q;
    logic [SW-1:0]    state_d;
    logic [SW-1:0]    next_s;
    logic             match_s;
    logic             hit_s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    seq_det_next #(
        .N       (N),
        .PATTERN (PATTERN),
        .OVERLAP (OVERLAP),
        .SW      (SW)
    ) u_next (
        .state_i (state_q),
        .x_i     (x_in),
        .next_o  (next_s),
        .match_o (match_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: advance only on qualified bits.
    always_comb begin
        if (x_valid) begin
            state_d = next_s;
        end else begin
            state_d = state_q;
        end
    end

    // Output decode: a match only counts on a valid bit outside reset.
    always_comb begin
        hit_s = rstn & x_valid & match_s;
    end

    // Counter next value; clear beats a coincident match.
    always_comb begin
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hit_s && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Match counter register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef SEQ_DET_REGOUT_EN
    logic y_q;
    logic y_d;

    // Registered pulse source.
    always_comb begin
        y_d = hit_s;
    end

    // Output pulse register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            y_q <= 1'b0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y_out = y_q;
`else
    assign y_out = hit_s;
`endif

    assign match_cnt = cnt_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_seq_det_fsm.sv
// Scoreboard bench for seq_det_fsm: three instances (overlap, non-overlap, fallback pattern)
// share one stimulus stream and are checked against a bit-history reference model.
module tb_seq_det_fsm;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, x_in, x_valid, cnt_clr;
    logic       y_a, y_b, y_c;
    logic [1:0] st_a, st_b, st_c;
    logic [1:0] cnt_a;
    logic [7:0] cnt_b;
    logic [2:0] cnt_c;

    seq_det_fsm #(.N(4), .PATTERN(16'b1011), .OVERLAP(1), .CNT_W(2)) dut_a (
        .clk(clk), .rstn(rstn), .x_in(x_in), .x_valid(x_valid), .cnt_clr(cnt_clr),
        .y_out(y_a), .match_cnt(cnt_a), .state_out(st_a));
    seq_det_fsm #(.N(4), .PATTERN(16'b1011), .OVERLAP(0), .CNT_W(8)) dut_b (
        .clk(clk), .rstn(rstn), .x_in(x_in), .x_valid(x_valid), .cnt_clr(cnt_clr),
        .y_out(y_b), .match_cnt(cnt_b), .state_out(st_b));
    seq_det_fsm #(.N(4), .PATTERN(16'b1101), .OVERLAP(1), .CNT_W(3)) dut_c (
        .clk(clk), .rstn(rstn), .x_in(x_in), .x_valid(x_valid), .cnt_clr(cnt_clr),
        .y_out(y_c), .match_cnt(cnt_c), .state_out(st_c));

    typedef struct packed {
        logic [2:0]      y;
        logic [2:0][1:0] st;
        logic [2:0][7:0] cnt;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: history of accepted bits (bit 0 newest) per instance.
    logic [15:0] pat  [3];
    bit          ovl  [3];
    int          cmax [3];
    logic [15:0] hist [3];
    int          hlen [3];
    int          mcnt [3];
    bit          myreg[3];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // True when the newest j bits of h equal the first j pattern bits.
    function automatic bit tail_is_prefix(logic [15:0] h, int len, logic [15:0] p, int j);
        if (len < j) return 1'b0;
        for (int i = 0; i < j; i++)
            if (h[i] != p[N-j+i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int mdl_state(int d);
        for (int j = N-1; j > 0; j--)
            if (tail_is_prefix(hist[d], hlen[d], pat[d], j)) return j;
        return 0;
    endfunction

    function automatic void mdl_reset();
        for (int d = 0; d < 3; d++) begin
            hist[d] = 16'h0; hlen[d] = 0; mcnt[d] = 0; myreg[d] = 1'b0;
        end
    endfunction

    // Apply one cycle of inputs, queue the expected outputs, advance the model.
    task automatic cycle(input logic r, input logic v, input logic x, input logic c);
        rec_t e;
        bit   m;
        logic [15:0] nh;
        rstn = r; x_valid = v; x_in = x; cnt_clr = c;
        for (int d = 0; d < 3; d++) begin
            nh = {hist[d][14:0], x};
            m  = v && tail_is_prefix(nh, hlen[d] + 1, pat[d], N);
`ifdef SEQ_DET_REGOUT_EN
            e.y[d] = myreg[d];
`else
            e.y[d] = r && m;
`endif
            e.st[d]  = 2'(mdl_state(d));
            e.cnt[d] = 8'(mcnt[d]);
            if (r) begin
                myreg[d] = m;
                if (v) begin
                    hist[d] = nh;
                    hlen[d] = (hlen[d] < 16) ? hlen[d] + 1 : 16;
                    if (m && !ovl[d]) hlen[d] = 0;
                end
                if (c) mcnt[d] = 0;
                else if (m && mcnt[d] < cmax[d]) mcnt[d]++;
            end
        end
        if (!r) mdl_reset();
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic bits(input logic [15:0] b, input int len);
        for (int i = len - 1; i >= 0; i--) cycle(1'b1, 1'b1, b[i], 1'b0);
    endtask

    // Monitor: compare every presented cycle mid-period against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("y_a",   {7'd0, y_a}, {7'd0, mon_e.y[0]});
            chk("y_b",   {7'd0, y_b}, {7'd0, mon_e.y[1]});
            chk("y_c",   {7'd0, y_c}, {7'd0, mon_e.y[2]});
            chk("st_a",  {6'd0, st_a}, {6'd0, mon_e.st[0]});
            chk("st_b",  {6'd0, st_b}, {6'd0, mon_e.st[1]});
            chk("st_c",  {6'd0, st_c}, {6'd0, mon_e.st[2]});
            chk("cnt_a", {6'd0, cnt_a}, mon_e.cnt[0]);
            chk("cnt_b", cnt_b, mon_e.cnt[1]);
            chk("cnt_c", {5'd0, cnt_c}, mon_e.cnt[2]);
        end
    end

    initial begin
        pat[0] = 16'b1011; ovl[0] = 1'b1; cmax[0] = 3;
        pat[1] = 16'b1011; ovl[1] = 1'b0; cmax[1] = 255;
        pat[2] = 16'b1101; ovl[2] = 1'b1; cmax[2] = 7;
        mdl_reset();
        rstn = 1'b0; x_valid = 1'b0; x_in = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_st_a", {6'd0, st_a}, 8'd0);
        chk("reset_cnt_b", cnt_b, 8'd0);

        // Overlap / non-overlap stream 1,0,1,1,0,1,1.
        bits(16'b1011011, 7);
        chk("ovl_cnt", {6'd0, cnt_a}, 8'd2);
        chk("ovl_state", {6'd0, st_a}, 8'd1);
        chk("novl_cnt", cnt_b, 8'd1);
        chk("novl_state", {6'd0, st_b}, 8'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Valid gap: state holds at 3 through three invalid cycles.
        bits(16'b101, 3);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("gap_state", {6'd0, st_a}, 8'd3);
        bits(16'b1, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // KMP fallback for 1101: 1,1,1,0,1.
        bits(16'b11101, 5);
        chk("fallback_cnt", {5'd0, cnt_c}, 8'd1);

        // Reset mid-match, then a partial and a full pattern.
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        bits(16'b101, 3);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        chk("midreset_state", {6'd0, st_a}, 8'd0);
        bits(16'b011, 3);
        chk("partial_cnt", {6'd0, cnt_a}, 8'd0);
        bits(16'b1011, 4);
        chk("full_cnt", {6'd0, cnt_a}, 8'd1);

        // Saturation then clear coinciding with a match.
        repeat (5) bits(16'b1011, 4);
        chk("sat_cnt", {6'd0, cnt_a}, 8'd3);
        bits(16'b101, 3);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr_prio_cnt", {6'd0, cnt_a}, 8'd0);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 99) >= 2) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0);
        end

        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
